// File: rtl/panxi_pkg.sv
// rtl/panxi_pkg.sv - shared types and constants for the PANXI pipeline controller
package panxi_pkg;

  localparam int XLEN = 32;

  // Pipeline register control encoding
  typedef enum logic [1:0] {
    HOLD_PASS  = 2'b00,
    HOLD_FLUSH = 2'b01,
    HOLD_STALL = 2'b10
  } hold_e;

  // IDLE: normal flow; JUMP_PEND: redirect waiting for fetch to complete
  typedef enum logic {
    IDLE      = 1'b0,
    JUMP_PEND = 1'b1
  } ctrl_state_e;

endpackage

// File: rtl/panxi_perf_cnt.sv
// rtl/panxi_perf_cnt.sv - 32-bit wrapping event counter with increment enable
module panxi_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        inc_en,
  output logic [31:0] count
);

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  // Next count: wraps naturally modulo 2^32
  always_comb begin
    cnt_d = cnt_q;
    if (rst) begin
      cnt_d = '0;
    end else if (inc_en) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign count = cnt_q;

endmodule

// File: rtl/panxi_pipe_ctrl.sv
// rtl/panxi_pipe_ctrl.sv - pipeline hold/flush controller; PANXI_CTRL_PERF_EN adds stall/flush counters
import panxi_pkg::*;

module panxi_pipe_ctrl #(
  parameter int XLEN = panxi_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_bus_wait,
  input  logic            id_load_use,
  input  logic            ex_jump_req,
  input  logic [XLEN-1:0] ex_jump_addr,
  input  logic            ex_div_busy,
  input  logic            mem_bus_wait,
  output logic [1:0]      hold_if_id,
  output logic [1:0]      hold_id_ex,
  output logic [1:0]      hold_ex_mem,
  output logic [1:0]      hold_mem_wb,
  output logic            pc_hold,
  output logic            pc_jump,
`ifdef PANXI_CTRL_PERF_EN
  output logic [31:0]     perf_stall_cnt,
  output logic [31:0]     perf_flush_cnt,
`endif
  output logic [XLEN-1:0] pc_jump_addr
);

  ctrl_state_e     state_q, state_d;
  logic [XLEN-1:0] pend_addr_q, pend_addr_d;
  hold_e           if_id, id_ex, ex_mem, mem_wb;

  // Priority resolution of stall/redirect requests and next-state logic
  always_comb begin
    if_id        = HOLD_PASS;
    id_ex        = HOLD_PASS;
    ex_mem       = HOLD_PASS;
    mem_wb       = HOLD_PASS;
    pc_hold      = 1'b0;
    pc_jump      = 1'b0;
    pc_jump_addr = (state_q == JUMP_PEND) ? pend_addr_q : ex_jump_addr;
    state_d      = state_q;
    pend_addr_d  = pend_addr_q;
    if (rst) begin
      if_id       = HOLD_FLUSH;
      id_ex       = HOLD_FLUSH;
      ex_mem      = HOLD_FLUSH;
      mem_wb      = HOLD_FLUSH;
      state_d     = IDLE;
      pend_addr_d = '0;
    end else if (state_q == IDLE) begin
      if (mem_bus_wait) begin
        pc_hold = 1'b1;
        if_id   = HOLD_STALL;
        id_ex   = HOLD_STALL;
        ex_mem  = HOLD_STALL;
        mem_wb  = HOLD_FLUSH;
      end else if (ex_div_busy) begin
        pc_hold = 1'b1;
        if_id   = HOLD_STALL;
        id_ex   = HOLD_STALL;
        ex_mem  = HOLD_FLUSH;
      end else if (ex_jump_req) begin
        // A same-cycle load-use belongs to the wrong path, so it is dropped here
        if_id = HOLD_FLUSH;
        id_ex = HOLD_FLUSH;
        if (if_bus_wait) begin
          pc_hold     = 1'b1;
          pend_addr_d = ex_jump_addr;
          state_d     = JUMP_PEND;
        end else begin
          pc_jump = 1'b1;
        end
      end else if (id_load_use) begin
        pc_hold = 1'b1;
        if_id   = HOLD_STALL;
        id_ex   = HOLD_FLUSH;
      end else if (if_bus_wait) begin
        pc_hold = 1'b1;
        if_id   = HOLD_FLUSH;
      end
    end else begin
      // Downstream stalls still apply, but the replay only waits on fetch
      if_id = HOLD_FLUSH;
      if (mem_bus_wait) begin
        pc_hold = 1'b1;
        id_ex   = HOLD_STALL;
        ex_mem  = HOLD_STALL;
        mem_wb  = HOLD_FLUSH;
      end else if (ex_div_busy) begin
        pc_hold = 1'b1;
        id_ex   = HOLD_STALL;
        ex_mem  = HOLD_FLUSH;
      end
      if (if_bus_wait) begin
        pc_hold = 1'b1;
      end else begin
        pc_jump = 1'b1;
        state_d = IDLE;
      end
    end
  end

  // State and pending redirect target registers
  always_ff @(posedge clk) begin
    state_q     <= state_d;
    pend_addr_q <= pend_addr_d;
  end

  assign hold_if_id  = if_id;
  assign hold_id_ex  = id_ex;
  assign hold_ex_mem = ex_mem;
  assign hold_mem_wb = mem_wb;

`ifdef PANXI_CTRL_PERF_EN
  logic stall_evt;
  logic flush_evt;

  assign stall_evt = pc_hold & ~pc_jump;
  assign flush_evt = ~rst & ((state_q == JUMP_PEND) |
                     ((state_q == IDLE) & ex_jump_req & ~mem_bus_wait & ~ex_div_busy));

  panxi_perf_cnt u_stall_cnt (
    .clk    (clk),
    .rst    (rst),
    .inc_en (stall_evt),
    .count  (perf_stall_cnt)
  );

  panxi_perf_cnt u_flush_cnt (
    .clk    (clk),
    .rst    (rst),
    .inc_en (flush_evt),
    .count  (perf_flush_cnt)
  );
`endif

endmodule

// File: doc/panxi_pipe_ctrl.md
# panxi_pipe_ctrl

Pipeline hold/flush controller for the PANXI RV32 five-stage core. Collects stall and redirect requests from IF, ID, EX and MEM and drives the 2-bit hold_en input of every inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB), plus the PC update controls. It holds a redirect that arrives while instruction fetch is stalled and replays it when fetch completes.

## Interface
Parameters:
- XLEN, 32, PC/address width

Ports. One clock; reset is synchronous and active-high.
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- if_bus_wait  in  1  instruction bus not ready this cycle
- id_load_use  in  1  ID instruction depends on a load in EX
- ex_jump_req  in  1  branch taken / jump resolved in EX
- ex_jump_addr  in  XLEN  redirect target
- ex_div_busy  in  1  multi-cycle divide occupying EX
- mem_bus_wait  in  1  data bus not ready in MEM
- hold_if_id, hold_id_ex, hold_ex_mem, hold_mem_wb  out  2 each  pipeline register control: 2'b00 pass, 2'b01 flush (load bubble), 2'b10 hold
- pc_hold  out  1  keep PC
- pc_jump  out  1  load PC from pc_jump_addr; overrides pc_hold
- pc_jump_addr  out  XLEN  redirect target

## Operation
- States: IDLE, JUMP_PEND. Register pend_addr (XLEN) holds the target latched in JUMP_PEND.
- Priority, highest first: mem_bus_wait > ex_div_busy > ex_jump_req > id_load_use > if_bus_wait. Each stage output takes the value from the highest-priority active rule that names it. Otherwise the output is 00.
- mem_bus_wait: pc_hold=1. if_id, id_ex and ex_mem = 10. mem_wb = 01. ex_jump_req is ignored because EX is held and the request persists.
- ex_div_busy: pc_hold=1. if_id and id_ex = 10. ex_mem = 01. ex_jump_req is ignored.
- ex_jump_req (IDLE only):
  - if_id and id_ex = 01.
  - If if_bus_wait=0: pc_jump=1 and pc_jump_addr=ex_jump_addr.
  - If if_bus_wait=1: pc_hold=1, latch pend_addr=ex_jump_addr and go to JUMP_PEND.
  - id_load_use is overridden, because that instruction is on the wrong path.
- id_load_use: pc_hold=1. if_id = 10. id_ex = 01.
- if_bus_wait (IDLE, no other rule active): pc_hold=1. if_id = 01.
- JUMP_PEND:
  - if_id = 01 every cycle, dropping the wrong-path fetch.
  - ex_jump_req and id_load_use are ignored.
  - While if_bus_wait=1: pc_hold=1.
  - The first cycle with if_bus_wait=0: pc_jump=1 and pc_jump_addr=pend_addr, then go to IDLE. This happens even when mem_bus_wait or ex_div_busy is active, since those only affect the downstream stage outputs.
- pc_jump_addr = ex_jump_addr in IDLE and pend_addr in JUMP_PEND.

## Timing
- All hold_*/pc_* outputs are combinational from the inputs and the state. Zero-cycle latency: the pipeline registers and PC act on them at the same clk edge.
- State and pend_addr update on the clk edge. Redirect-while-fetch-stalled costs one or more cycles in JUMP_PEND, plus the IDLE cycle that detected it.
- While rst=1:
  - All hold_* = 01 and pc_hold = pc_jump = 0.
  - Next state is IDLE, pend_addr is 0 and the counters are 0.
  - Reset in JUMP_PEND discards the pending redirect.

## Configuration
- PANXI_CTRL_PERF_EN defined: adds outputs perf_stall_cnt [31:0] and perf_flush_cnt [31:0].
  - perf_stall_cnt increments each cycle with pc_hold=1 and pc_jump=0.
  - perf_flush_cnt increments each cycle in which a redirect flushes if_id (ex_jump_req accepted, or JUMP_PEND).
  - Both counters are 0 on reset and wrap modulo 2^32.
- Undefined: the ports and logic are absent. Behaviour is otherwise identical.

## Structure
- panxi_pkg: typedef enum logic [1:0] hold_e {HOLD_PASS=2'b00, HOLD_FLUSH=2'b01, HOLD_STALL=2'b10}, the state enum ctrl_state_e, and the constant XLEN=32.
- One sub-module, panxi_perf_cnt: a 32-bit counter with an increment enable, instantiated twice under the macro.

## Test plan
- Reset: rst=1 with mem_bus_wait=1 -> all hold_*=01, pc_hold=0, pc_jump=0. After release with no requests -> all 00.
- Load-use: id_load_use=1 for 1 cycle -> pc_hold=1, if_id=10, id_ex=01, ex_mem=mem_wb=00.
- Jump with fetch ready: ex_jump_req=1, addr=0x0000_0100 -> pc_jump=1, pc_jump_addr=0x100, if_id=id_ex=01. Same-cycle id_load_use=1 has no effect.
- Jump during fetch stall: ex_jump_req=1, addr=0x0000_0200, if_bus_wait=1 for 3 cycles.
  - Enter JUMP_PEND with pc_hold=1 and if_id=01 throughout.
  - The cycle if_bus_wait falls: pc_jump=1, pc_jump_addr=0x200, then IDLE.
- Stall priority: mem_bus_wait=1, ex_div_busy=1, ex_jump_req=1 -> pc_jump=0, if_id=id_ex=ex_mem=10, mem_wb=01. Drop mem_bus_wait -> ex_mem=01, jump still suppressed.
- PERF (macro on): 5 load-use cycles and 2 accepted jumps -> perf_stall_cnt=5, perf_flush_cnt=2. Preload to 0xFFFF_FFFF and stall once -> 0.
